pipeline_hazard_ctrl: RTL and testbench
=======================================

Name: pipeline_hazard_ctrl

Overview:
- Central stall/flush sequencer for the 5-stage RV32 pipeline.
- Drives the enable and flush inputs of the IF/ID, ID/EX, EX/MEM and MEM/WB enable-flip-flop banks, plus the PC register enable.
- Resolves load-use hazards, taken-branch flushes, data-memory wait states, and a multi-cycle execute unit (mul/div) through a start/done/ack handshake.
- Keeps a saturating stall-cycle performance counter.

Parameters:
- REG_ADDR_W, 5, register-index width.
- CNT_W, 16, width of stall_cycles.
- MC_TIMEOUT, 64, multi-cycle wait limit in cycles (used only with MC_TIMEOUT_EN).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous active-low reset.
- id_rs1, id_rs2  in  REG_ADDR_W  source registers of the instruction in ID.
- id_use_rs1, id_use_rs2  in  1  ID instruction reads rs1/rs2.
- ex_rd  in  REG_ADDR_W  destination register of the instruction in EX.
- ex_is_load  in  1  EX instruction is a load.
- ex_branch_taken  in  1  EX resolved a taken branch or jump.
- ex_mc_op  in  1  EX holds a multi-cycle op.
- mc_done  in  1  multi-cycle unit result valid; held high until mc_ack.
- mem_wait  in  1  data memory not ready.
- pc_en, ifid_en, idex_en, exmem_en, memwb_en  out  1  register-bank enables.
- ifid_flush, idex_flush, exmem_flush  out  1  load a bubble (zero) into the bank this edge.
- mc_start  out  1  one-cycle start pulse to the multi-cycle unit.
- mc_ack  out  1  result consumed; the unit drops mc_done next cycle.
- mc_error  out  1  timeout pulse (MC_TIMEOUT_EN only).
- stall_cycles  out  CNT_W  count of cycles with pc_en=0, saturating.

Behaviour:
- State register {RUN, MC_WAIT}, reset to RUN. Outputs are combinational from state and inputs.
- While rst=0: all enables, flushes, mc_start, mc_ack and mc_error are 0; stall_cycles=0.
- Priority, highest first: mem_wait > ex_branch_taken > MC handling > load-use > normal.
- mem_wait=1, any state:
  - all enables 0, all flushes 0, mc_start 0, mc_ack 0.
  - state and timeout counter hold; mc_done is ignored.
- RUN, normal: all enables 1, all flushes 0.
- RUN, ex_branch_taken=1:
  - all enables 1; ifid_flush=1 and idex_flush=1, i.e. two bubbles.
  - any concurrent load-use condition is ignored; stay in RUN.
- RUN, ex_mc_op=1 (and no branch):
  - mc_start=1; pc_en, ifid_en and idex_en are 0.
  - exmem_en=1 with exmem_flush=1; memwb_en=1.
  - next state MC_WAIT; timeout counter cleared.
- RUN, load-use:
  - condition: ex_is_load & (ex_rd!=0) & ((id_use_rs1 & id_rs1==ex_rd) | (id_use_rs2 & id_rs2==ex_rd)).
  - pc_en=0, ifid_en=0, idex_en=1 with idex_flush=1; exmem_en=1, memwb_en=1.
  - exactly one stall cycle; stay in RUN.
- MC_WAIT, mc_done=0:
  - pc/ifid/idex enables 0; exmem_flush=1 with exmem_en=1; memwb_en=1.
  - timeout counter increments.
- MC_WAIT, mc_done=1:
  - mc_ack=1; all enables 1, flushes 0; the result is captured into EX/MEM.
  - next state RUN.
- A new ex_mc_op is accepted only from RUN, so back-to-back multi-cycle ops re-enter MC_WAIT after one RUN cycle.
- stall_cycles increments by 1 every cycle with rst=1 and pc_en=0, and saturates at all-ones.
- Reset asserted mid-MC_WAIT: immediate return to RUN; no mc_ack is issued. The multi-cycle unit is reset by the same rst.

Optional Feature:
- Macro: MC_TIMEOUT_EN.
- Defined:
  - In MC_WAIT, when the counter reaches MC_TIMEOUT-1 with mc_done=0, assert mc_error=1 and mc_ack=1 for one cycle.
  - On that cycle: exmem_flush=1 (result discarded); pc/ifid/idex enables 1; return to RUN.
  - mc_done arriving on the timeout cycle wins: normal completion, no error.
- Undefined: no timeout counter; MC_WAIT waits indefinitely; mc_error is tied 0.

Test Plan:
- Reset: rst=0 then release → all outputs 0 during reset; first cycle after release has all enables 1, stall_cycles=0.
- Load-use: ex_is_load=1, ex_rd=5, id_rs2=5, id_use_rs2=1 → one cycle with pc_en=0, ifid_en=0, idex_flush=1; stall_cycles=1. Repeat with ex_rd=0 → no stall.
- Branch beats load-use: ex_branch_taken=1 with a simultaneous load-use match → ifid_flush=1, idex_flush=1, pc_en=1; stall_cycles unchanged.
- Multi-cycle: ex_mc_op=1, mc_done raised 10 cycles after mc_start → mc_start for 1 cycle; upstream frozen and exmem_flush=1 for 10 cycles; then mc_ack=1 with all enables 1; stall_cycles=11.
- mem_wait during MC_WAIT: mem_wait=1 for 3 cycles while mc_done=1 → all enables 0 and no mc_ack during those cycles; mc_ack on the first cycle after mem_wait drops.
- Timeout (MC_TIMEOUT_EN, MC_TIMEOUT=8): mc_done never raised → mc_error=1 and mc_ack=1 exactly on the 8th MC_WAIT cycle, exmem_flush=1, back in RUN. Without the macro: still in MC_WAIT after 100 cycles, mc_error=0.

Source files
------------

// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard-control bundle between the RV32 pipeline datapath and pipeline_hazard_ctrl.
// master: datapath side (drives hazard status, receives bank controls).
// slave : the hazard controller.
interface pipeline_hazard_ctrl_if #(
  parameter int unsigned REG_ADDR_W = 5,
  parameter int unsigned CNT_W      = 16
) ();

  // Hazard status from ID/EX/MEM and the multi-cycle unit
  logic [REG_ADDR_W-1:0] id_rs1;
  logic [REG_ADDR_W-1:0] id_rs2;
  logic                  id_use_rs1;
  logic                  id_use_rs2;
  logic [REG_ADDR_W-1:0] ex_rd;
  logic                  ex_is_load;
  logic                  ex_branch_taken;
  logic                  ex_mc_op;
  logic                  mc_done;
  logic                  mem_wait;

  // Bank controls, multi-cycle handshake and performance counter
  logic                  pc_en;
  logic                  ifid_en;
  logic                  idex_en;
  logic                  exmem_en;
  logic                  memwb_en;
  logic                  ifid_flush;
  logic                  idex_flush;
  logic                  exmem_flush;
  logic                  mc_start;
  logic                  mc_ack;
  logic                  mc_error;
  logic [CNT_W-1:0]      stall_cycles;

  modport master (
    output id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_rd, ex_is_load,
           ex_branch_taken, ex_mc_op, mc_done, mem_wait,
    input  pc_en, ifid_en, idex_en, exmem_en, memwb_en,
           ifid_flush, idex_flush, exmem_flush,
           mc_start, mc_ack, mc_error, stall_cycles
  );

  modport slave (
    input  id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_rd, ex_is_load,
           ex_branch_taken, ex_mc_op, mc_done, mem_wait,
    output pc_en, ifid_en, idex_en, exmem_en, memwb_en,
           ifid_flush, idex_flush, exmem_flush,
           mc_start, mc_ack, mc_error, stall_cycles
  );

endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Central stall/flush sequencer for the 5-stage RV32 pipeline.
// Bank enables/flushes are combinational from state and hazard inputs;
// stall_cycles is a registered saturating count of cycles with pc_en=0.
// Optional: define MC_TIMEOUT_EN to abort a multi-cycle op that has not
// completed within MC_TIMEOUT MC_WAIT cycles (mc_error + mc_ack pulse).
module pipeline_hazard_ctrl #(
  parameter int unsigned REG_ADDR_W = 5,
  parameter int unsigned CNT_W      = 16,
  parameter int unsigned MC_TIMEOUT = 64
) (
  input logic                    clk,
  input logic                    rst,
  pipeline_hazard_ctrl_if.slave  hz
);

  localparam logic [REG_ADDR_W-1:0] REG_X0 = '0;

  typedef enum logic {
    RUN     = 1'b0,
    MC_WAIT = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] stall_q, stall_d;
  logic             load_use_c;
  logic             mc_error_c;

`ifdef MC_TIMEOUT_EN
  localparam int unsigned     TO_W    = $clog2(MC_TIMEOUT + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(MC_TIMEOUT - 1);

  logic [TO_W-1:0] to_q, to_d;
`else
  logic unused_timeout;
  assign unused_timeout = ^32'(MC_TIMEOUT);
`endif

  // Load-use: a load in EX writes a register the ID instruction reads (x0 never hazards)
  assign load_use_c = hz.ex_is_load && (hz.ex_rd != REG_X0) &&
                      ((hz.id_use_rs1 && (hz.id_rs1 == hz.ex_rd)) ||
                       (hz.id_use_rs2 && (hz.id_rs2 == hz.ex_rd)));

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= RUN;
    end else begin
      state_q <= state_d;
    end
  end

`ifdef MC_TIMEOUT_EN
  // Multi-cycle wait counter
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      to_q <= '0;
    end else begin
      to_q <= to_d;
    end
  end
`endif

  // Next state and bank controls; mem_wait freezes everything including the wait counter
  always_comb begin
    state_d        = state_q;
    hz.pc_en       = 1'b0;
    hz.ifid_en     = 1'b0;
    hz.idex_en     = 1'b0;
    hz.exmem_en    = 1'b0;
    hz.memwb_en    = 1'b0;
    hz.ifid_flush  = 1'b0;
    hz.idex_flush  = 1'b0;
    hz.exmem_flush = 1'b0;
    hz.mc_start    = 1'b0;
    hz.mc_ack      = 1'b0;
    mc_error_c     = 1'b0;
`ifdef MC_TIMEOUT_EN
    to_d           = to_q;
`endif

    if (!rst) begin
      state_d = RUN;
    end else if (!hz.mem_wait) begin
      case (state_q)
        RUN: begin
          if (hz.ex_branch_taken) begin
            // Two bubbles behind the redirect; a stale load-use match is moot
            hz.pc_en      = 1'b1;
            hz.ifid_en    = 1'b1;
            hz.idex_en    = 1'b1;
            hz.exmem_en   = 1'b1;
            hz.memwb_en   = 1'b1;
            hz.ifid_flush = 1'b1;
            hz.idex_flush = 1'b1;
          end else if (hz.ex_mc_op) begin
            // Launch the unit, freeze upstream, drain a bubble downstream
            hz.mc_start    = 1'b1;
            hz.exmem_en    = 1'b1;
            hz.exmem_flush = 1'b1;
            hz.memwb_en    = 1'b1;
            state_d        = MC_WAIT;
`ifdef MC_TIMEOUT_EN
            to_d           = '0;
`endif
          end else if (load_use_c) begin
            // Hold IF/ID one cycle and insert a bubble into ID/EX
            hz.idex_en    = 1'b1;
            hz.idex_flush = 1'b1;
            hz.exmem_en   = 1'b1;
            hz.memwb_en   = 1'b1;
          end else begin
            hz.pc_en    = 1'b1;
            hz.ifid_en  = 1'b1;
            hz.idex_en  = 1'b1;
            hz.exmem_en = 1'b1;
            hz.memwb_en = 1'b1;
          end
        end

        MC_WAIT: begin
          // EX holds the multi-cycle op here, so a taken branch cannot be present
          if (hz.mc_done) begin
            hz.mc_ack   = 1'b1;
            hz.pc_en    = 1'b1;
            hz.ifid_en  = 1'b1;
            hz.idex_en  = 1'b1;
            hz.exmem_en = 1'b1;
            hz.memwb_en = 1'b1;
            state_d     = RUN;
          end
`ifdef MC_TIMEOUT_EN
          else if (to_q == TO_LAST) begin
            // Give up: release the unit, discard its slot, resume fetch
            mc_error_c     = 1'b1;
            hz.mc_ack      = 1'b1;
            hz.pc_en       = 1'b1;
            hz.ifid_en     = 1'b1;
            hz.idex_en     = 1'b1;
            hz.exmem_en    = 1'b1;
            hz.memwb_en    = 1'b1;
            hz.exmem_flush = 1'b1;
            state_d        = RUN;
          end
`endif
          else begin
            hz.exmem_en    = 1'b1;
            hz.exmem_flush = 1'b1;
            hz.memwb_en    = 1'b1;
`ifdef MC_TIMEOUT_EN
            to_d           = to_q + TO_W'(1);
`endif
          end
        end

        default: state_d = RUN;
      endcase
    end
  end

  assign hz.mc_error = mc_error_c;

  // Saturating count of cycles where the PC is held
  always_comb begin
    stall_d = stall_q;
    if (!hz.pc_en && (stall_q != '1)) begin
      stall_d = stall_q + CNT_W'(1);
    end
  end

  // Stall counter register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_q <= '0;
    end else begin
      stall_q <= stall_d;
    end
  end

  assign hz.stall_cycles = stall_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl: directed scenarios plus a
// randomized run checked against a cycle-level behavioural model.
module tb_pipeline_hazard_ctrl;

  localparam int unsigned RW     = 5;
  localparam int unsigned CW     = 8;
  localparam int unsigned MC_TO  = 8;
  localparam int          STALL_MAX = (1 << CW) - 1;
`ifdef MC_TIMEOUT_EN
  localparam bit TO_EN  = 1'b1;
  localparam int MC_LAT = 5;
`else
  localparam bit TO_EN  = 1'b0;
  localparam int MC_LAT = 10;
`endif

  // Output vector bit masks
  localparam logic [10:0] B_PC    = 11'h400;
  localparam logic [10:0] B_IFID  = 11'h200;
  localparam logic [10:0] B_IDEX  = 11'h100;
  localparam logic [10:0] B_EXMEM = 11'h080;
  localparam logic [10:0] B_MEMWB = 11'h040;
  localparam logic [10:0] F_IFID  = 11'h020;
  localparam logic [10:0] F_IDEX  = 11'h010;
  localparam logic [10:0] F_EXMEM = 11'h008;
  localparam logic [10:0] P_START = 11'h004;
  localparam logic [10:0] P_ACK   = 11'h002;
  localparam logic [10:0] P_ERR   = 11'h001;
  localparam logic [10:0] ALL_EN  = B_PC | B_IFID | B_IDEX | B_EXMEM | B_MEMWB;
  localparam logic [10:0] MC_HOLD = B_EXMEM | B_MEMWB | F_EXMEM;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_vec = 0;
  int   n_err = 0;

  // Model state: is a multi-cycle op outstanding, how long has it waited, stall count
  bit m_busy  = 1'b0;
  int m_wait  = 0;
  int m_stall = 0;

  pipeline_hazard_ctrl_if #(.REG_ADDR_W(RW), .CNT_W(CW)) hz ();

  pipeline_hazard_ctrl #(
    .REG_ADDR_W(RW),
    .CNT_W     (CW),
    .MC_TIMEOUT(MC_TO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .hz (hz)
  );

  always #5 clk = ~clk;

  function automatic logic [10:0] outs();
    return {hz.pc_en, hz.ifid_en, hz.idex_en, hz.exmem_en, hz.memwb_en,
            hz.ifid_flush, hz.idex_flush, hz.exmem_flush,
            hz.mc_start, hz.mc_ack, hz.mc_error};
  endfunction

  task automatic set_idle();
    hz.id_rs1 = '0; hz.id_rs2 = '0; hz.id_use_rs1 = 1'b0; hz.id_use_rs2 = 1'b0;
    hz.ex_rd = '0; hz.ex_is_load = 1'b0; hz.ex_branch_taken = 1'b0;
    hz.ex_mc_op = 1'b0; hz.mc_done = 1'b0; hz.mem_wait = 1'b0;
  endtask

  task automatic set_random_hazards();
    hz.id_rs1          = RW'($urandom_range(0, 3));
    hz.id_rs2          = RW'($urandom_range(0, 3));
    hz.ex_rd           = RW'($urandom_range(0, 3));
    hz.id_use_rs1      = 1'($urandom_range(0, 1));
    hz.id_use_rs2      = 1'($urandom_range(0, 1));
    hz.ex_is_load      = ($urandom_range(0, 2) == 0);
    hz.ex_branch_taken = ($urandom_range(0, 5) == 0);
    hz.ex_mc_op        = ($urandom_range(0, 6) == 0);
    hz.mem_wait        = ($urandom_range(0, 4) == 0);
  endtask

  // Expected controls for the current cycle, from the priority rules
  task automatic model_eval(output logic [10:0] e, output bit nb, output int nw);
    bit lu;
    lu = hz.ex_is_load && (int'(hz.ex_rd) != 0) &&
         ((hz.id_use_rs1 && hz.id_rs1 == hz.ex_rd) || (hz.id_use_rs2 && hz.id_rs2 == hz.ex_rd));
    e  = '0;
    nb = m_busy;
    nw = m_wait;
    if (!rst || hz.mem_wait) begin
      e = '0;
    end else if (!m_busy) begin
      if (hz.ex_branch_taken)  e = ALL_EN | F_IFID | F_IDEX;
      else if (hz.ex_mc_op) begin
        e = MC_HOLD | P_START; nb = 1'b1; nw = 0;
      end
      else if (lu)             e = B_IDEX | F_IDEX | B_EXMEM | B_MEMWB;
      else                     e = ALL_EN;
    end else begin
      if (hz.mc_done) begin
        e = ALL_EN | P_ACK; nb = 1'b0;
      end else if (TO_EN && m_wait == int'(MC_TO) - 1) begin
        e = ALL_EN | F_EXMEM | P_ACK | P_ERR; nb = 1'b0;
      end else begin
        e = MC_HOLD; nw = m_wait + 1;
      end
    end
  endtask

  // One clock: sample DUT and model mid-cycle, then advance the model on the edge
  task automatic tick(output logic [10:0] got, output logic [10:0] exp,
                      output int sg, output int se);
    bit nb;
    int nw;
    @(negedge clk);
    if (!rst) begin m_busy = 1'b0; m_wait = 0; m_stall = 0; end
    model_eval(exp, nb, nw);
    got = outs();
    sg  = int'(hz.stall_cycles);
    se  = m_stall;
    @(posedge clk);
    if (rst) begin
      m_busy = nb;
      m_wait = nw;
      if (!exp[10]) m_stall = (m_stall >= STALL_MAX) ? STALL_MAX : m_stall + 1;
    end
    #1;
  endtask

  task automatic apply_reset();
    logic [10:0] g, e;
    int sg, se;
    set_idle();
    rst = 1'b0;
    tick(g, e, sg, se);
    tick(g, e, sg, se);
    rst = 1'b1;
  endtask

  task automatic test_reset();
    logic [10:0] g, e;
    int sg, se;
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      set_random_hazards();
      hz.mc_done = 1'($urandom_range(0, 1));
      tick(g, e, sg, se);
      n_vec++;
      if (g !== 11'h000) begin n_err++; $display("FAIL reset_outs: got %b want %b", g, 11'h000); end
      n_vec++;
      if (sg !== 0) begin n_err++; $display("FAIL reset_stall: got %0d want 0", sg); end
    end
    set_idle();
    rst = 1'b1;
    tick(g, e, sg, se);
    n_vec++;
    if (g !== ALL_EN) begin n_err++; $display("FAIL reset_release: got %b want %b", g, ALL_EN); end
    n_vec++;
    if (sg !== 0) begin n_err++; $display("FAIL reset_release_stall: got %0d want 0", sg); end
  endtask

  task automatic test_load_use();
    logic [10:0] g, e;
    int sg, se;
    apply_reset();
    hz.ex_is_load = 1'b1; hz.ex_rd = 5'd5; hz.id_rs2 = 5'd5; hz.id_use_rs2 = 1'b1;
    hz.id_rs1 = 5'd3; hz.id_use_rs1 = 1'b1;
    tick(g, e, sg, se);
    n_vec++;
    if (g !== (B_IDEX | F_IDEX | B_EXMEM | B_MEMWB)) begin
      n_err++; $display("FAIL lu_stall: got %b want %b", g, B_IDEX | F_IDEX | B_EXMEM | B_MEMWB);
    end
    set_idle();
    tick(g, e, sg, se);
    n_vec++;
    if (g !== ALL_EN) begin n_err++; $display("FAIL lu_resume: got %b want %b", g, ALL_EN); end
    n_vec++;
    if (sg !== 1) begin n_err++; $display("FAIL lu_stall_cnt: got %0d want 1", sg); end
    hz.ex_is_load = 1'b1; hz.ex_rd = 5'd0; hz.id_rs2 = 5'd0; hz.id_use_rs2 = 1'b1;
    tick(g, e, sg, se);
    n_vec++;
    if (g !== ALL_EN) begin n_err++; $display("FAIL lu_x0: got %b want %b", g, ALL_EN); end
    set_idle();
    tick(g, e, sg, se);
    n_vec++;
    if (sg !== 1) begin n_err++; $display("FAIL lu_x0_cnt: got %0d want 1", sg); end
  endtask

  task automatic test_branch_over_load_use();
    logic [10:0] g, e;
    int sg, se;
    apply_reset();
    hz.ex_is_load = 1'b1; hz.ex_rd = 5'd7; hz.id_rs1 = 5'd7; hz.id_use_rs1 = 1'b1;
    hz.ex_branch_taken = 1'b1;
    tick(g, e, sg, se);
    n_vec++;
    if (g !== (ALL_EN | F_IFID | F_IDEX)) begin
      n_err++; $display("FAIL br_flush: got %b want %b", g, ALL_EN | F_IFID | F_IDEX);
    end
    set_idle();
    tick(g, e, sg, se);
    n_vec++;
    if (sg !== 0) begin n_err++; $display("FAIL br_stall_cnt: got %0d want 0", sg); end
  endtask

  task automatic test_multicycle();
    logic [10:0] g, e;
    int sg, se;
    apply_reset();
    hz.ex_mc_op = 1'b1;
    tick(g, e, sg, se);
    n_vec++;
    if (g !== (MC_HOLD | P_START)) begin n_err++; $display("FAIL mc_start: got %b want %b", g, MC_HOLD | P_START); end
    for (int i = 0; i < MC_LAT; i++) begin
      tick(g, e, sg, se);
      n_vec++;
      if (g !== MC_HOLD) begin n_err++; $display("FAIL mc_wait%0d: got %b want %b", i, g, MC_HOLD); end
    end
    hz.mc_done = 1'b1;
    tick(g, e, sg, se);
    n_vec++;
    if (g !== (ALL_EN | P_ACK)) begin n_err++; $display("FAIL mc_ack: got %b want %b", g, ALL_EN | P_ACK); end
    n_vec++;
    if (sg !== MC_LAT + 1) begin n_err++; $display("FAIL mc_stall_cnt: got %0d want %0d", sg, MC_LAT + 1); end
    set_idle();
    tick(g, e, sg, se);
    n_vec++;
    if (g !== ALL_EN) begin n_err++; $display("FAIL mc_resume: got %b want %b", g, ALL_EN); end
  endtask

  task automatic test_back_to_back();
    logic [10:0] g, e;
    int sg, se;
    apply_reset();
    hz.ex_mc_op = 1'b1;
    tick(g, e, sg, se);
    hz.mc_done = 1'b1;
    tick(g, e, sg, se);
    n_vec++;
    if (g !== (ALL_EN | P_ACK)) begin n_err++; $display("FAIL b2b_ack1: got %b want %b", g, ALL_EN | P_ACK); end
    hz.mc_done = 1'b0;
    tick(g, e, sg, se);
    n_vec++;
    if (g !== (MC_HOLD | P_START)) begin n_err++; $display("FAIL b2b_start2: got %b want %b", g, MC_HOLD | P_START); end
    tick(g, e, sg, se);
    n_vec++;
    if (g !== MC_HOLD) begin n_err++; $display("FAIL b2b_wait2: got %b want %b", g, MC_HOLD); end
    hz.mc_done = 1'b1;
    tick(g, e, sg, se);
    n_vec++;
    if (g !== (ALL_EN | P_ACK)) begin n_err++; $display("FAIL b2b_ack2: got %b want %b", g, ALL_EN | P_ACK); end
    set_idle();
    tick(g, e, sg, se);
    n_vec++;
    if (sg !== 3) begin n_err++; $display("FAIL b2b_stall_cnt: got %0d want 3", sg); end
  endtask

  task automatic test_mem_wait_in_mc();
    logic [10:0] g, e;
    int sg, se;
    apply_reset();
    hz.ex_mc_op = 1'b1;
    tick(g, e, sg, se);
    tick(g, e, sg, se);
    tick(g, e, sg, se);
    hz.mc_done = 1'b1;
    hz.mem_wait = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick(g, e, sg, se);
      n_vec++;
      if (g !== 11'h000) begin n_err++; $display("FAIL mw_freeze%0d: got %b want %b", i, g, 11'h000); end
    end
    hz.mem_wait = 1'b0;
    tick(g, e, sg, se);
    n_vec++;
    if (g !== (ALL_EN | P_ACK)) begin n_err++; $display("FAIL mw_ack: got %b want %b", g, ALL_EN | P_ACK); end
    n_vec++;
    if (sg !== 6) begin n_err++; $display("FAIL mw_stall_cnt: got %0d want 6", sg); end
    set_idle();
    tick(g, e, sg, se);
  endtask

  task automatic test_timeout();
    logic [10:0] g, e;
    int sg, se;
    apply_reset();
    hz.ex_mc_op = 1'b1;
    tick(g, e, sg, se);
`ifdef MC_TIMEOUT_EN
    for (int i = 1; i < int'(MC_TO); i++) begin
      tick(g, e, sg, se);
      n_vec++;
      if (g !== MC_HOLD) begin n_err++; $display("FAIL to_wait%0d: got %b want %b", i, g, MC_HOLD); end
    end
    tick(g, e, sg, se);
    n_vec++;
    if (g !== (ALL_EN | F_EXMEM | P_ACK | P_ERR)) begin
      n_err++; $display("FAIL to_error: got %b want %b", g, ALL_EN | F_EXMEM | P_ACK | P_ERR);
    end
    hz.ex_mc_op = 1'b0;
    tick(g, e, sg, se);
    n_vec++;
    if (g !== ALL_EN) begin n_err++; $display("FAIL to_resume: got %b want %b", g, ALL_EN); end
    // Completion on the timeout cycle wins
    hz.ex_mc_op = 1'b1;
    tick(g, e, sg, se);
    for (int i = 1; i < int'(MC_TO); i++) tick(g, e, sg, se);
    hz.mc_done = 1'b1;
    tick(g, e, sg, se);
    n_vec++;
    if (g !== (ALL_EN | P_ACK)) begin n_err++; $display("FAIL to_done_wins: got %b want %b", g, ALL_EN | P_ACK); end
`else
    for (int i = 0; i < 100; i++) begin
      tick(g, e, sg, se);
      n_vec++;
      if (g !== MC_HOLD) begin n_err++; $display("FAIL to_nowait%0d: got %b want %b", i, g, MC_HOLD); end
    end
    hz.mc_done = 1'b1;
    tick(g, e, sg, se);
    n_vec++;
    if (g !== (ALL_EN | P_ACK)) begin n_err++; $display("FAIL to_late_ack: got %b want %b", g, ALL_EN | P_ACK); end
`endif
    set_idle();
    tick(g, e, sg, se);
  endtask

  task automatic test_saturation();
    logic [10:0] g, e;
    int sg, se;
    apply_reset();
    hz.mem_wait = 1'b1;
    for (int i = 0; i < STALL_MAX + 6; i++) begin
      tick(g, e, sg, se);
      if (i % 50 == 0 || i >= STALL_MAX - 1) begin
        n_vec++;
        if (sg !== ((i > STALL_MAX) ? STALL_MAX : i)) begin
          n_err++; $display("FAIL sat_cnt%0d: got %0d want %0d", i, sg, (i > STALL_MAX) ? STALL_MAX : i);
        end
      end
    end
    set_idle();
    tick(g, e, sg, se);
    n_vec++;
    if (sg !== STALL_MAX) begin n_err++; $display("FAIL sat_hold: got %0d want %0d", sg, STALL_MAX); end
  endtask

  // Random traffic; the bench plays the multi-cycle unit
  task automatic test_random();
    logic [10:0] g, e;
    int sg, se;
    bit mc_active = 1'b0;
    bit mc_hold   = 1'b0;
    int mc_left   = 0;
    apply_reset();
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 199) != 0);
      if (!rst) begin mc_active = 1'b0; mc_hold = 1'b0; end
      set_random_hazards();
      hz.mc_done = mc_hold;
      tick(g, e, sg, se);
      n_vec++;
      if (g !== e) begin n_err++; $display("FAIL rand_outs@%0d: got %b want %b", i, g, e); end
      n_vec++;
      if (sg !== se) begin n_err++; $display("FAIL rand_stall@%0d: got %0d want %0d", i, sg, se); end
      if (rst) begin
        if (e[1]) begin mc_active = 1'b0; mc_hold = 1'b0; end
        if (e[2]) begin
          mc_active = 1'b1;
          mc_left   = int'($urandom_range(0, 11));
        end else if (mc_active && !mc_hold) begin
          if (mc_left == 0) mc_hold = 1'b1;
          else mc_left--;
        end
      end
    end
    rst = 1'b1;
    set_idle();
  endtask

  initial begin
    set_idle();
    test_reset();
    test_load_use();
    test_branch_over_load_use();
    test_multicycle();
    test_back_to_back();
    test_mem_wait_in_mc();
    test_timeout();
    test_saturation();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
